// File: rtl/skew_fifo_bank_if.sv
// Handshake and data bundle for skew_fifo_bank.
// master: the producer/consumer side (drives flush, wr_en, din, rd_en).
// slave : the FIFO bank itself (drives dout and the status flags).
// Ports carried: flush, wr_en, din, rd_en, dout, empty, full, almost_full,
//   level, ovf, udf.
interface skew_fifo_bank_if #(
  parameter int LANES  = 4,
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8
);
  logic                      flush;
  logic                      wr_en;
  logic [LANES*DWIDTH-1:0]   din;
  logic                      rd_en;
  logic [LANES*DWIDTH-1:0]   dout;
  logic                      empty;
  logic                      full;
  logic                      almost_full;
  logic [$clog2(DEPTH):0]    level;
  logic                      ovf;
  logic                      udf;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, empty, full, almost_full, level, ovf, udf
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, empty, full, almost_full, level, ovf, udf
  );
endinterface

// File: rtl/skew_fifo_bank.sv
// Multi-lane single-clock FIFO bank feeding the systolic array edge.
// All lanes push and pop in lockstep. With SKEW_EN=1, lane i starts out
// holding i zero words, so its user data emerges i pops after lane 0's.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous reset, active high
//   bus  - skew_fifo_bank_if.slave (flush, wr_en, din, rd_en in;
//          dout, empty, full, almost_full, level, ovf, udf out)
module skew_fifo_bank #(
  parameter int LANES    = 4,
  parameter int DWIDTH   = 16,
  parameter int DEPTH    = 8,
  parameter int SKEW_EN  = 1,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic             clk,
  input  logic             rstn,
  skew_fifo_bank_if.slave  bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int PMAX   = (LANES - 1) * SKEW_EN;
  // Lane LANES-1 carries the largest prefill, so it fills first.
  localparam int MAXLVL = DEPTH - PMAX;

  logic [DWIDTH-1:0] mem [LANES][DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [LW-1:0]     level;
  logic              ovf;
  logic              udf;
  logic              empty;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(MAXLVL));
  // A pop in the same cycle frees the slot a full push needs.
  assign push_ok = bus.wr_en & (~full | bus.rd_en);
  // No bypass: a push into an empty bank cannot be popped in the same cycle.
  assign pop_ok  = bus.rd_en & ~empty;

  // Clearing the storage is what creates the leading zero words: lane i's
  // write address is offset by i, so slots rptr..rptr+i-1 read back as zero.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < LANES; i++)
        for (int j = 0; j < DEPTH; j++)
          mem[i][j] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < LANES; i++)
        for (int j = 0; j < DEPTH; j++)
          mem[i][j] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (push_ok) begin
        for (int i = 0; i < LANES; i++)
          mem[i][wptr + AW'(i * SKEW_EN)] <= bus.din[i*DWIDTH +: DWIDTH];
        wptr <= wptr + AW'(1);
      end
      if (pop_ok)
        rptr <= rptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
      if (bus.wr_en & ~push_ok)
        ovf <= 1'b1;
      if (bus.rd_en & ~pop_ok)
        udf <= 1'b1;
    end
  end

  // First-word fall-through: every lane presents its head combinationally.
  for (genvar g = 0; g < LANES; g++) begin : g_dout
    assign bus.dout[g*DWIDTH +: DWIDTH] = mem[g][rptr];
  end

  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (level >= LW'(AF_LEVEL));
  assign bus.level       = level;
  assign bus.ovf         = ovf;
  assign bus.udf         = udf;
endmodule
